switch_scheduler: RTL and testbench

Cycle-by-cycle crossbar scheduler for the 4-port switch: it takes head-of-line requests and destination masks from the four `switch_port` instances and issues one-cycle FIFO pop grants. One cycle later it drives the output-mux selects and output-active strobes. Allocation is round-robin with multicast all-or-nothing and an aging override against starvation. It sits between the `switch_port` instances and the `output_mux` instances in `switch_4port`.

---
 rtl/switch_scheduler.sv | 122 ++++++++++++
 tb/tb_switch_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/switch_scheduler.sv
// Crossbar scheduler for the 4-port switch: round-robin allocation with all-or-nothing
// multicast and age-based starvation override, issuing pop grants then output-mux selects.
module switch_scheduler #(
  parameter int NUM_PORTS    = 4,
  parameter int ADDR_WIDTH   = 4,
  parameter int AGE_WIDTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             port_reqs,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  dst_bus,
  input  logic                             cfg_enable,
  output logic [NUM_PORTS-1:0]             grant_bus,
  output logic [NUM_PORTS*2-1:0]           mux_sel_bus,
  output logic [NUM_PORTS-1:0]             active_bus,
  output logic                             err_null_dst
);

  localparam int SEL_W = $clog2(NUM_PORTS);

  logic [ADDR_WIDTH-1:0] dst       [NUM_PORTS];
  logic [AGE_WIDTH-1:0]  age       [NUM_PORTS];
  logic [NUM_PORTS-1:0]  elig;
  logic [NUM_PORTS-1:0]  starving;
  logic [NUM_PORTS-1:0]  normal;
  logic [NUM_PORTS-1:0]  null_dst;
  logic [SEL_W-1:0]      rr_ptr;

  logic [NUM_PORTS-1:0]  grant_nxt;
  logic [ADDR_WIDTH-1:0] claimed;
  logic [SEL_W-1:0]      own_nxt   [ADDR_WIDTH];
  logic [SEL_W-1:0]      idx;
  logic [SEL_W-1:0]      first_idx;
  logic                  first_found;
  logic                  cand;

  logic [ADDR_WIDTH-1:0] vld_p0;
  logic [SEL_W-1:0]      own_p0    [ADDR_WIDTH];

  function automatic logic [AGE_WIDTH-1:0] sat_inc(input logic [AGE_WIDTH-1:0] a);
    return (&a) ? a : a + AGE_WIDTH'(1);
  endfunction

  // A pending pop makes an input ineligible: its request/mask still describe the popped head.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      dst[i]      = dst_bus[i*ADDR_WIDTH +: ADDR_WIDTH];
      null_dst[i] = (dst[i] == '0);
      elig[i]     = port_reqs[i] && !null_dst[i] && !grant_bus[i];
      starving[i] = elig[i] && (age[i] >= AGE_WIDTH'(STARVE_LIMIT));
      normal[i]   = elig[i] && !starving[i];
    end
  end

  // Two passes from rr_ptr: starving class, then normal class. Each input lives in one class.
  always_comb begin
    grant_nxt   = '0;
    claimed     = '0;
    idx         = '0;
    first_idx   = '0;
    first_found = 1'b0;
    cand        = 1'b0;
    for (int o = 0; o < ADDR_WIDTH; o++) own_nxt[o] = '0;
    for (int k = 0; k < 2*NUM_PORTS; k++) begin
      idx  = rr_ptr + k[SEL_W-1:0];
      cand = (k < NUM_PORTS) ? starving[idx] : normal[idx];
      if (cfg_enable && cand && ((dst[idx] & claimed) == '0)) begin
        grant_nxt[idx] = 1'b1;
        claimed        = claimed | dst[idx];
        for (int o = 0; o < ADDR_WIDTH; o++) begin
          if (dst[idx][o]) own_nxt[o] = idx;
        end
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = idx;
        end
      end
    end
  end

  // ---- stage p0: pop grant, claim record, ages, round-robin pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_bus    <= '0;
      vld_p0       <= '0;
      rr_ptr       <= '0;
      err_null_dst <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) age[i] <= '0;
    end else begin
      grant_bus    <= grant_nxt;
      vld_p0       <= claimed;
      err_null_dst <= |(port_reqs & ~grant_bus & null_dst);
      if (|grant_nxt) rr_ptr <= first_idx + SEL_W'(1);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_nxt[i] || !port_reqs[i]) begin
          age[i] <= '0;
        end else if (cfg_enable && elig[i]) begin
          age[i] <= sat_inc(age[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < ADDR_WIDTH; o++) own_p0[o] <= own_nxt[o];
  end

  // ---- stage p1: output-mux selects and active strobes, aligned with popped head data ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bus  <= '0;
      mux_sel_bus <= '0;
    end else begin
      active_bus <= vld_p0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        mux_sel_bus[o*SEL_W +: SEL_W] <= vld_p0[o] ? own_p0[o] : '0;
      end
    end
  end

endmodule

// File: tb/tb_switch_scheduler.sv
// Directed bench for switch_scheduler: per-cycle vector table plus an asynchronous
// reset-mid-transfer sequence. Runs the DUT with a starvation limit of 3.
module tb_switch_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  port_reqs = '0;
  logic [15:0] dst_bus = '0;
  logic        cfg_enable = 1'b1;
  logic [3:0]  grant_bus;
  logic [7:0]  mux_sel_bus;
  logic [3:0]  active_bus;
  logic        err_null_dst;

  int tests = 0;
  int fails = 0;

  switch_scheduler #(
    .NUM_PORTS(4), .ADDR_WIDTH(4), .AGE_WIDTH(4), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .port_reqs(port_reqs), .dst_bus(dst_bus),
    .cfg_enable(cfg_enable), .grant_bus(grant_bus), .mux_sel_bus(mux_sel_bus),
    .active_bus(active_bus), .err_null_dst(err_null_dst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  reqs;
    logic [15:0] dst;
    logic        en;
    logic [3:0]  g;
    logic [3:0]  act;
    logic [7:0]  sel;
    logic        err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] reqs, input logic [15:0] dst,
                     input logic en, input logic [3:0] g, input logic [3:0] act,
                     input logic [7:0] sel, input logic err);
    vec_t v;
    v.rst = r; v.reqs = reqs; v.dst = dst; v.en = en;
    v.g = g; v.act = act; v.sel = sel; v.err = err;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int n, input logic [15:0] got,
                     input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, n, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    port_reqs  = '0;
    dst_bus    = '0;
    cfg_enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Four-input contention on output 0
    add(1, 4'hF, 16'h1111, 1, 4'b0001, 4'b0000, 8'h00, 0);
    add(0, 4'hF, 16'h1111, 1, 4'b0010, 4'b0001, 8'h00, 0);
    add(0, 4'hF, 16'h1111, 1, 4'b0100, 4'b0001, 8'h01, 0);
    add(0, 4'hF, 16'h1111, 1, 4'b1000, 4'b0001, 8'h02, 0);
    add(0, 4'hF, 16'h1111, 1, 4'b0001, 4'b0001, 8'h03, 0);
    add(0, 4'hF, 16'h1111, 1, 4'b0010, 4'b0001, 8'h00, 0);
    // Disjoint destinations
    add(1, 4'hF, 16'h1842, 1, 4'b1111, 4'b0000, 8'h00, 0);
    add(0, 4'h0, 16'h1842, 1, 4'b0000, 4'b1111, 8'h93, 0);
    // Multicast versus unicast with rr_ptr moved to 2
    add(1, 4'h2, 16'h0010, 1, 4'b0010, 4'b0000, 8'h00, 0);
    add(0, 4'h0, 16'h0010, 1, 4'b0000, 4'b0001, 8'h01, 0);
    add(0, 4'h5, 16'h0206, 1, 4'b0100, 4'b0000, 8'h00, 0);
    add(0, 4'h5, 16'h0206, 1, 4'b0001, 4'b0010, 8'h08, 0);
    add(0, 4'h0, 16'h0206, 1, 4'b0000, 4'b0110, 8'h00, 0);
    add(0, 4'h0, 16'h0206, 1, 4'b0000, 4'b0000, 8'h00, 0);
    // Multicast input 1 against output-3 traffic
    add(1, 4'hF, 16'h88F8, 1, 4'b0001, 4'b0000, 8'h00, 0);
    add(0, 4'hF, 16'h88F8, 1, 4'b0010, 4'b1000, 8'h00, 0);
    add(0, 4'hF, 16'h88F8, 1, 4'b0100, 4'b1111, 8'h55, 0);
    add(0, 4'hF, 16'h88F8, 1, 4'b1000, 4'b1000, 8'h80, 0);
    add(0, 4'hF, 16'h88F8, 1, 4'b0001, 4'b1000, 8'hC0, 0);
    add(0, 4'hF, 16'h88F8, 1, 4'b0010, 4'b1000, 8'h00, 0);
    add(0, 4'h0, 16'h88F8, 1, 4'b0000, 4'b1111, 8'h55, 0);
    // Null destination holds input 2's age; once starving it beats input 1 at rr_ptr
    add(1, 4'h7, 16'h0111, 1, 4'b0001, 4'b0000, 8'h00, 0);
    add(0, 4'h7, 16'h0111, 1, 4'b0010, 4'b0001, 8'h00, 0);
    add(0, 4'h7, 16'h0011, 1, 4'b0001, 4'b0001, 8'h01, 1);
    add(0, 4'h7, 16'h0111, 1, 4'b0010, 4'b0001, 8'h00, 0);
    add(0, 4'h7, 16'h0011, 1, 4'b0001, 4'b0001, 8'h01, 1);
    add(0, 4'h7, 16'h0111, 1, 4'b0100, 4'b0001, 8'h00, 0);
    add(0, 4'h0, 16'h0111, 1, 4'b0000, 4'b0001, 8'h02, 0);
    // Enable low for 3 cycles: pending strobe completes, ages hold
    add(1, 4'hE, 16'h1120, 1, 4'b0110, 4'b0000, 8'h00, 0);
    add(0, 4'hE, 16'h1120, 0, 4'b0000, 4'b0011, 8'h06, 0);
    add(0, 4'hE, 16'h1120, 0, 4'b0000, 4'b0000, 8'h00, 0);
    add(0, 4'hE, 16'h1120, 0, 4'b0000, 4'b0000, 8'h00, 0);
    add(0, 4'hE, 16'h1120, 1, 4'b0110, 4'b0000, 8'h00, 0);
    add(0, 4'hE, 16'h1120, 1, 4'b1000, 4'b0011, 8'h06, 0);
    add(0, 4'h0, 16'h1120, 1, 4'b0000, 4'b0001, 8'h03, 0);

    // Reset state
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_grant", -1, 16'(grant_bus), 16'h0);
    chk("rst_active", -1, 16'(active_bus), 16'h0);
    chk("rst_sel", -1, 16'(mux_sel_bus), 16'h0);
    chk("rst_err", -1, 16'(err_null_dst), 16'h0);

    foreach (vq[n]) begin
      if (vq[n].rst) do_reset();
      port_reqs  = vq[n].reqs;
      dst_bus    = vq[n].dst;
      cfg_enable = vq[n].en;
      @(posedge clk); #1;
      chk("grant", n, 16'(grant_bus), 16'(vq[n].g));
      chk("active", n, 16'(active_bus), 16'(vq[n].act));
      chk("sel", n, 16'(mux_sel_bus), 16'(vq[n].sel));
      chk("err", n, 16'(err_null_dst), 16'(vq[n].err));
    end

    // Asynchronous reset while grant_bus = 0001 is in flight
    do_reset();
    port_reqs = 4'hF;
    dst_bus   = 16'h1111;
    @(posedge clk); #1;
    chk("mid_grant_pre", 100, 16'(grant_bus), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_grant_async", 101, 16'(grant_bus), 16'h0);
    chk("mid_active_async", 101, 16'(active_bus), 16'h0);
    chk("mid_sel_async", 101, 16'(mux_sel_bus), 16'h0);
    chk("mid_err_async", 101, 16'(err_null_dst), 16'h0);
    @(posedge clk); #1;
    chk("mid_active_held", 102, 16'(active_bus), 16'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_grant", 103, 16'(grant_bus), 16'h1);
    chk("post_active", 103, 16'(active_bus), 16'h0);
    @(posedge clk); #1;
    chk("post_grant2", 104, 16'(grant_bus), 16'h2);
    chk("post_active2", 104, 16'(active_bus), 16'h1);
    chk("post_sel2", 104, 16'(mux_sel_bus), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
